// File: rtl/rr_mux41_pkg.sv
// Shared types and constants for the rr_mux41_arb round-robin arbiter.
// Optional build macro: ARB_PRIO0_EN (requester 0 gets absolute priority).
package rr_mux41_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : rr_mux41_pkg

// File: rtl/rr_pick4.sv
// Combinational 4-way rotating priority picker.
// The search starts at ptr and walks ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
// With ARB_PRIO0_EN defined, req[0] overrides the rotation whenever it is set.
module rr_pick4
    import rr_mux41_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] index
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down to ptr so the nearest pending requester is written last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        valid = 1'b0;
        index = ptr;
        cand  = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
`ifdef ARB_PRIO0_EN
        if (req[0]) begin
            valid = 1'b1;
            index = '0;
        end
`endif
    end

endmodule : rr_pick4

// File: rtl/rr_mux41_arb.sv
// Round-robin arbiter in front of a shared 4:1 mux channel with a valid/ready output.
// A grant is held, with sel and out_data frozen, until the consumer accepts the word.
// Within the accept cycle the next winner is chosen, so the channel runs back-to-back.
// Optional build macro: ARB_PRIO0_EN (requester 0 wins whenever eligible; its grants leave ptr alone).
module rr_mux41_arb
    import rr_mux41_pkg::*;
#(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data_i,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   sel,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [W-1:0]       data_q, data_d;

    logic               accept;
    logic [SEL_W-1:0]   ptr_adv;
    logic [N_REQ-1:0]   pick_req;
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic [W-1:0]       pick_data;

    assign out_valid = (state_q == BUSY);
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign gnt       = gnt_q;

    assign accept = out_valid & out_ready;
    assign ack    = gnt_q & {N_REQ{accept}};

    // Pointer moves past the requester just served; priority-0 grants do not rotate it.
`ifdef ARB_PRIO0_EN
    assign ptr_adv = (sel_q == '0) ? ptr_q : sel_q + SEL_W'(1);
`else
    assign ptr_adv = sel_q + SEL_W'(1);
`endif
    assign ptr_d = accept ? ptr_adv : ptr_q;

    // In BUSY only the accept-cycle result is used; the served requester is masked so it cannot be re-granted at once.
    assign pick_req = (state_q == BUSY) ? (req & ~gnt_q) : req;

    rr_pick4 u_pick (
        .req   (pick_req),
        .ptr   (ptr_d),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // 4:1 data mux selecting the winner's word for capture.
    always_comb begin
        pick_data = data_i[0 +: W];
        case (pick_idx)
            2'd0:    pick_data = data_i[0*W +: W];
            2'd1:    pick_data = data_i[1*W +: W];
            2'd2:    pick_data = data_i[2*W +: W];
            default: pick_data = data_i[3*W +: W];
        endcase
    end

    // Next-state logic: grant from IDLE, hold under backpressure, re-arbitrate on accept.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    sel_d   = pick_idx;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    data_d  = pick_data;
                end
            end
            BUSY: begin
                if (accept) begin
                    if (pick_valid) begin
                        sel_d  = pick_idx;
                        gnt_d  = N_REQ'(1) << pick_idx;
                        data_d = pick_data;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample its pre-edge inputs, independent of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
        end
    end

endmodule : rr_mux41_arb

// File: tb/tb_rr_mux41_arb.sv
// Directed self-checking bench for rr_mux41_arb (W = 8).
module tb_rr_mux41_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_i;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  sel;
    logic [3:0]  gnt;
    logic [3:0]  ack;

    int checks = 0;
    int errors = 0;

    rr_mux41_arb #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_i    (data_i),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .gnt       (gnt),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [3:0] r, input logic rdy);
        rst_n     = 1'b0;
        req       = r;
        out_ready = rdy;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        data_i = 32'h44332211;
        do_reset(4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, sel, gnt, ack, out_data} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b sel=%0d gnt=%b ack=%b data=%h, want all zero",
                     out_valid, sel, gnt, ack, out_data);
        end
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({out_valid, sel, gnt, ack, out_data} !== {1'b1, 2'd0, 4'b0001, 4'b0000, 8'h11}) begin
            errors++;
            $display("FAIL reset_first_grant: got v=%b sel=%0d gnt=%b ack=%b data=%h, want v=1 sel=0 gnt=0001 ack=0000 data=11",
                     out_valid, sel, gnt, ack, out_data);
        end
        // Reset while BUSY: everything returns to zero without an ack.
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({out_valid, sel, gnt, ack, out_data} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid_busy: got v=%b sel=%0d gnt=%b ack=%b data=%h, want all zero",
                     out_valid, sel, gnt, ack, out_data);
        end
        rst_n = 1'b1;
        req   = 4'b0000;
    endtask

    task automatic test_single();
        do_reset(4'b0000, 1'b1);
        data_i = 32'h00A50000;
        req    = 4'b0100;
        #1;
        checks++;
        if ({out_valid, gnt, ack} !== 9'd0) begin
            errors++;
            $display("FAIL single_idle: got v=%b gnt=%b ack=%b, want 0 0000 0000", out_valid, gnt, ack);
        end
        tick();
        checks++;
        if ({out_valid, sel, gnt, ack, out_data} !== {1'b1, 2'd2, 4'b0100, 4'b0100, 8'hA5}) begin
            errors++;
            $display("FAIL single_grant: got v=%b sel=%0d gnt=%b ack=%b data=%h, want v=1 sel=2 gnt=0100 ack=0100 data=a5",
                     out_valid, sel, gnt, ack, out_data);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({out_valid, gnt, ack} !== 9'd0) begin
            errors++;
            $display("FAIL single_back_idle: got v=%b gnt=%b ack=%b, want 0 0000 0000", out_valid, gnt, ack);
        end
    endtask

    task automatic test_fairness();
`ifdef ARB_PRIO0_EN
        int order[5] = '{0, 1, 0, 2, 0};
`else
        int order[5] = '{0, 1, 2, 3, 0};
`endif
        logic [3:0] exp_gnt;
        logic [7:0] exp_data;
        do_reset(4'hF, 1'b1);
        data_i = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_gnt  = 4'b0001 << order[k];
            exp_data = 8'h10 + 8'(order[k]);
            checks++;
            if ({out_valid, sel, gnt, ack, out_data} !== {1'b1, 2'(order[k]), exp_gnt, exp_gnt, exp_data}) begin
                errors++;
                $display("FAIL fairness_step%0d: got v=%b sel=%0d gnt=%b ack=%b data=%h, want v=1 sel=%0d gnt=%b ack=%b data=%h",
                         k, out_valid, sel, gnt, ack, out_data, order[k], exp_gnt, exp_gnt, exp_data);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset(4'b0000, 1'b0);
        data_i = 32'h00001100;
        req    = 4'b0010;
        tick();
        for (int k = 0; k < 5; k++) begin
            data_i[15:8] = 8'h20 + 8'(k);
            req          = (k == 2) ? 4'b1111 : 4'b0010;
            #1;
            checks++;
            if ({out_valid, sel, gnt, ack, out_data} !== {1'b1, 2'd1, 4'b0010, 4'b0000, 8'h11}) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got v=%b sel=%0d gnt=%b ack=%b data=%h, want v=1 sel=1 gnt=0010 ack=0000 data=11",
                         k, out_valid, sel, gnt, ack, out_data);
            end
            tick();
        end
        req       = 4'b0010;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({ack, out_data} !== {4'b0010, 8'h11}) begin
            errors++;
            $display("FAIL backpressure_ack: got ack=%b data=%h, want ack=0010 data=11", ack, out_data);
        end
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if ({out_valid, gnt, ack} !== 9'd0) begin
            errors++;
            $display("FAIL backpressure_idle: got v=%b gnt=%b ack=%b, want 0 0000 0000", out_valid, gnt, ack);
        end
    endtask

    task automatic test_dup_guard();
        logic [3:0] exp_ack;
        int ack_count = 0;
        do_reset(4'b0000, 1'b1);
        data_i = 32'h77000000;
        req    = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_ack = (k % 2 == 0) ? 4'b1000 : 4'b0000;
            if (ack != 4'b0000) ack_count++;
            checks++;
            if ({out_valid, gnt, ack} !== {exp_ack[3], exp_ack, exp_ack}) begin
                errors++;
                $display("FAIL dup_guard_step%0d: got v=%b gnt=%b ack=%b, want v=%b gnt=%b ack=%b",
                         k, out_valid, gnt, ack, exp_ack[3], exp_ack, exp_ack);
            end
        end
        checks++;
        if (ack_count !== 3) begin
            errors++;
            $display("FAIL dup_guard_count: got %0d acks, want 3", ack_count);
        end
        req = 4'b0000;
    endtask

    task automatic test_prio_order();
`ifdef ARB_PRIO0_EN
        int order[6] = '{0, 1, 0, 3, 0, 1};
`else
        int order[6] = '{0, 1, 3, 0, 1, 3};
`endif
        do_reset(4'b1011, 1'b1);
        data_i = 32'h33222100;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({out_valid, sel, ack} !== {1'b1, 2'(order[k]), 4'b0001 << order[k]}) begin
                errors++;
                $display("FAIL prio_order_step%0d: got v=%b sel=%0d ack=%b, want v=1 sel=%0d",
                         k, out_valid, sel, ack, order[k]);
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        data_i    = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_dup_guard();
        test_prio_order();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_mux41_arb
